// File: rtl/z80_bus_ctrl.sv
// Z80 data-bus controller: decodes {m1,wr,rd,mreq} into PRAM fetch, DRAM and I/O accesses.
// Latency: WAIT+1 clocks from code sampling to registered read data or write strobe.
// Backpressure: cpu_wait is high while an access is in ACCESS; a held code is served only once.
module z80_bus_ctrl #(
    parameter int DATA_W    = 8,
    parameter int N_IO      = 4,
    parameter int IO_SEL_W  = 2,
    parameter int PRAM_WAIT = 0,
    parameter int DRAM_WAIT = 1,
    parameter int IO_WAIT   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m1,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     mreq,
    input  logic [IO_SEL_W-1:0]      io_sel,
    input  logic [DATA_W-1:0]        cpu_data_out,
    output logic [DATA_W-1:0]        cpu_data_in,
    output logic                     cpu_wait,
    output logic                     cycle_done,
    output logic                     bus_err,
    input  logic [DATA_W-1:0]        pram_data,
    input  logic [DATA_W-1:0]        dram_rdata,
    output logic [DATA_W-1:0]        dram_wdata,
    output logic                     dram_we,
    input  logic [N_IO*DATA_W-1:0]   io_rdata,
    output logic [DATA_W-1:0]        io_wdata,
    output logic [N_IO-1:0]          io_we
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;
    typedef enum logic [2:0] {A_NONE, A_FETCH, A_DRAM_RD, A_IO_RD, A_DRAM_WR, A_IO_WR} acc_t;

    state_t                 state;
    acc_t                   cur_acc;
    acc_t                   lat_acc;
    logic [3:0]             cnt;
    logic [3:0]             cur_wait;
    logic [IO_SEL_W-1:0]    lat_sel;
    logic [DATA_W-1:0]      lat_data;
    logic [DATA_W-1:0]      io_rd_mux;
    logic [N_IO-1:0]        io_we_dec;
    logic                   sel_ok;

    // Strobe code decode; anything not listed is treated as no access.
    always_comb begin
        case ({m1, wr, rd, mreq})
            4'b0100: cur_acc = A_FETCH;
            4'b1100: cur_acc = A_DRAM_RD;
            4'b1101: cur_acc = A_IO_RD;
            4'b1010: cur_acc = A_DRAM_WR;
            4'b1011: cur_acc = A_IO_WR;
            default: cur_acc = A_NONE;
        endcase
    end

    // Wait-state count for the access being started.
    always_comb begin
        case (cur_acc)
            A_FETCH:              cur_wait = 4'(PRAM_WAIT);
            A_DRAM_RD, A_DRAM_WR: cur_wait = 4'(DRAM_WAIT);
            A_IO_RD, A_IO_WR:     cur_wait = 4'(IO_WAIT);
            default:              cur_wait = 4'd0;
        endcase
    end

    // I/O channel decode from the latched select; an out-of-range select matches no channel,
    // which yields zero read data, no write strobe and sel_ok low.
    always_comb begin
        io_rd_mux = '0;
        io_we_dec = '0;
        for (int k = 0; k < N_IO; k++) begin
            if (32'(lat_sel) == 32'(k)) begin
                io_rd_mux    = io_rdata[k*DATA_W +: DATA_W];
                io_we_dec[k] = 1'b1;
            end
        end
        sel_ok = |io_we_dec;
    end

    // Access FSM with registered data, strobes and status; pulses default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            lat_acc     <= A_NONE;
            cnt         <= 4'd0;
            lat_sel     <= '0;
            lat_data    <= '0;
            cpu_data_in <= '0;
            dram_wdata  <= '0;
            io_wdata    <= '0;
            dram_we     <= 1'b0;
            io_we       <= '0;
            cpu_wait    <= 1'b0;
            cycle_done  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            bus_err    <= 1'b0;
            dram_we    <= 1'b0;
            io_we      <= '0;
            case (state)
                S_IDLE: begin
                    if (cur_acc != A_NONE) begin
                        lat_acc  <= cur_acc;
                        lat_sel  <= io_sel;
                        lat_data <= cpu_data_out;
                        cnt      <= cur_wait;
                        cpu_wait <= 1'b1;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cur_acc != lat_acc) begin
                        // CPU dropped or changed the strobes: abandon silently.
                        cnt      <= 4'd0;
                        cpu_wait <= 1'b0;
                        state    <= S_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        cpu_wait   <= 1'b0;
                        cycle_done <= 1'b1;
                        state      <= S_HOLD;
                        case (lat_acc)
                            A_FETCH:   cpu_data_in <= pram_data;
                            A_DRAM_RD: cpu_data_in <= dram_rdata;
                            A_IO_RD: begin
                                cpu_data_in <= io_rd_mux;
                                bus_err     <= !sel_ok;
                            end
                            A_DRAM_WR: begin
                                dram_wdata <= lat_data;
                                dram_we    <= 1'b1;
                            end
                            A_IO_WR: begin
                                io_wdata <= lat_data;
                                io_we    <= io_we_dec;
                                bus_err  <= !sel_ok;
                            end
                            default: ;
                        endcase
                    end
                end
                S_HOLD: begin
                    // Wait for the CPU to release the strobes so a held code is served once.
                    if (cur_acc == A_NONE) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
module tb_z80_bus_ctrl;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_FETCH = 4'b0100;
    localparam logic [3:0] C_DRD   = 4'b1100;
    localparam logic [3:0] C_IORD  = 4'b1101;
    localparam logic [3:0] C_DWR   = 4'b1010;
    localparam logic [3:0] C_IOWR  = 4'b1011;

    logic        clk = 1'b0;
    logic        reset;
    logic        m1, wr, rd, mreq;
    logic [1:0]  io_sel;
    logic [7:0]  cpu_data_out, pram_data, dram_rdata;
    logic [31:0] io_rdata;

    logic [7:0]  a_rd, a_dwd, a_iwd, b_rd, b_dwd, b_iwd;
    logic        a_wait, a_done, a_err, a_dwe, b_wait, b_done, b_err, b_dwe;
    logic [3:0]  a_iowe;
    logic [2:0]  b_iowe;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rd [2];
    logic [7:0] exp_dwd [2];
    logic [7:0] exp_iwd [2];
    int ob_wait [2];
    int ob_done [2];
    int ob_didx [2];
    int ob_dwe [2];
    int ob_err [2];
    logic [3:0] ob_iowe [2];

    always #5 clk = ~clk;

    z80_bus_ctrl #(.DATA_W(8), .N_IO(4), .IO_SEL_W(2), .PRAM_WAIT(0), .DRAM_WAIT(2), .IO_WAIT(3)) dut_a (
        .clk(clk), .reset(reset), .m1(m1), .wr(wr), .rd(rd), .mreq(mreq),
        .io_sel(io_sel), .cpu_data_out(cpu_data_out), .cpu_data_in(a_rd),
        .cpu_wait(a_wait), .cycle_done(a_done), .bus_err(a_err),
        .pram_data(pram_data), .dram_rdata(dram_rdata), .dram_wdata(a_dwd), .dram_we(a_dwe),
        .io_rdata(io_rdata), .io_wdata(a_iwd), .io_we(a_iowe)
    );

    z80_bus_ctrl #(.DATA_W(8), .N_IO(3), .IO_SEL_W(2), .PRAM_WAIT(0), .DRAM_WAIT(2), .IO_WAIT(3)) dut_b (
        .clk(clk), .reset(reset), .m1(m1), .wr(wr), .rd(rd), .mreq(mreq),
        .io_sel(io_sel), .cpu_data_out(cpu_data_out), .cpu_data_in(b_rd),
        .cpu_wait(b_wait), .cycle_done(b_done), .bus_err(b_err),
        .pram_data(pram_data), .dram_rdata(dram_rdata), .dram_wdata(b_dwd), .dram_we(b_dwe),
        .io_rdata(io_rdata[23:0]), .io_wdata(b_iwd), .io_we(b_iowe)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_code(input logic [3:0] c);
        {m1, wr, rd, mreq} = c;
    endtask

    // Layout: [31:24] cpu_data_in [23:16] dram_wdata [15:8] io_wdata [7] wait [6] done [5] err [4] dram_we [3:0] io_we
    function automatic logic [31:0] obs(input int i);
        if (i == 0) return {a_rd, a_dwd, a_iwd, a_wait, a_done, a_err, a_dwe, a_iowe};
        return {b_rd, b_dwd, b_iwd, b_wait, b_done, b_err, b_dwe, 1'b0, b_iowe};
    endfunction

    function automatic int wait_of(input logic [3:0] c);
        case (c)
            C_DRD, C_DWR:  return 2;
            C_IORD, C_IOWR: return 3;
            default:       return 0;
        endcase
    endfunction

    function automatic logic [7:0] io_slice(input logic [31:0] d, input int s, input int n);
        if (s >= n) return 8'h00;
        return d[s*8 +: 8];
    endfunction

    // Drive one CPU access: code present for 'hold' edges, then NONE for 'gap' edges.
    // Per the access rules, it completes only if the code survives W+2 sampling edges.
    task automatic run_txn(input logic [3:0] c, input logic [1:0] s, input logic [7:0] wd,
                           input int hold, input int gap, input string tag);
        int w, lim, n;
        bit comp, de, err_e, dwe_e, wait_e;
        logic [3:0] iowe_e;
        logic [31:0] av, ev;
        w = wait_of(c);
        comp = (hold >= w + 2);
        lim = (hold < w + 1) ? hold : w + 1;
        for (int i = 0; i < 2; i++) begin
            ob_wait[i] = 0; ob_done[i] = 0; ob_didx[i] = -1; ob_dwe[i] = 0; ob_err[i] = 0; ob_iowe[i] = 4'h0;
        end
        set_code(c);
        io_sel = s;
        cpu_data_out = wd;
        for (int j = 0; j < hold + gap; j++) begin
            @(posedge clk); #1;
            cpu_data_out = 8'($urandom);
            for (int i = 0; i < 2; i++) begin
                n = (i == 0) ? 4 : 3;
                de = comp && (j == w + 1);
                wait_e = (j < lim);
                err_e = 1'b0; dwe_e = 1'b0; iowe_e = 4'h0;
                if (de) begin
                    case (c)
                        C_FETCH: exp_rd[i] = pram_data;
                        C_DRD:   exp_rd[i] = dram_rdata;
                        C_IORD: begin
                            exp_rd[i] = io_slice(io_rdata, int'(s), n);
                            err_e = (int'(s) >= n);
                        end
                        C_DWR: begin
                            exp_dwd[i] = wd;
                            dwe_e = 1'b1;
                        end
                        C_IOWR: begin
                            exp_iwd[i] = wd;
                            err_e = (int'(s) >= n);
                            if (int'(s) < n) iowe_e = 4'b0001 << s;
                        end
                        default: ;
                    endcase
                end
                ev = {exp_rd[i], exp_dwd[i], exp_iwd[i], wait_e, de, err_e, dwe_e, iowe_e};
                av = obs(i);
                check($sformatf("%s_%s_cyc%0d", tag, (i == 0) ? "a" : "b", j), 64'(av), 64'(ev));
                if (av[7]) ob_wait[i]++;
                if (av[6]) begin ob_done[i]++; ob_didx[i] = j; end
                if (av[5]) ob_err[i]++;
                if (av[4]) ob_dwe[i]++;
                ob_iowe[i] = ob_iowe[i] | av[3:0];
            end
            if (j + 1 == hold) set_code(C_NONE);
        end
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [1:0]  sel;
        logic [7:0]  wd;
        logic [7:0]  pram;
        logic [7:0]  dram;
        logic [31:0] iord;
        int          hold;
        int          e_wait;
        int          e_didx;
        logic [7:0]  e_rd_a;
        logic [7:0]  e_rd_b;
        int          e_dwe;
        logic [3:0]  e_iowe_a;
        logic [3:0]  e_iowe_b;
        int          e_err_a;
        int          e_err_b;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0]  codes [5];
        logic [63:0] ov, xv;
        int          w, hold;
        logic [3:0]  c;

        tbl[0] = '{C_FETCH, 2'd0, 8'h00, 8'hA5, 8'h00, 32'h0,         3,  1,  1, 8'hA5, 8'hA5, 0, 4'h0, 4'h0, 0, 0};
        tbl[1] = '{C_DWR,   2'd0, 8'h3C, 8'h00, 8'h00, 32'h0,         10, 3,  3, 8'hA5, 8'hA5, 1, 4'h0, 4'h0, 0, 0};
        tbl[2] = '{C_IORD,  2'd2, 8'h00, 8'h00, 8'h00, 32'hFF7EFFFF,  6,  4,  4, 8'h7E, 8'h7E, 0, 4'h0, 4'h0, 0, 0};
        tbl[3] = '{C_IOWR,  2'd3, 8'h5A, 8'h00, 8'h00, 32'h0,         6,  4,  4, 8'h7E, 8'h7E, 0, 4'h8, 4'h0, 0, 1};
        tbl[4] = '{C_IORD,  2'd3, 8'h00, 8'h00, 8'h00, 32'h11223344,  5,  4,  4, 8'h11, 8'h00, 0, 4'h0, 4'h0, 0, 1};
        tbl[5] = '{C_DRD,   2'd0, 8'h00, 8'h00, 8'hC3, 32'h0,         2,  2, -1, 8'h11, 8'h00, 0, 4'h0, 4'h0, 0, 0};
        tbl[6] = '{C_DRD,   2'd0, 8'h00, 8'h00, 8'hC3, 32'h0,         4,  3,  3, 8'hC3, 8'hC3, 0, 4'h0, 4'h0, 0, 0};
        tbl[7] = '{C_FETCH, 2'd0, 8'h00, 8'h99, 8'h00, 32'h0,         1,  1, -1, 8'hC3, 8'hC3, 0, 4'h0, 4'h0, 0, 0};
        tbl[8] = '{C_IOWR,  2'd0, 8'h77, 8'h00, 8'h00, 32'h0,         5,  4,  4, 8'hC3, 8'hC3, 0, 4'h1, 4'h1, 0, 0};
        codes[0] = C_FETCH; codes[1] = C_DRD; codes[2] = C_IORD; codes[3] = C_DWR; codes[4] = C_IOWR;

        reset = 1'b1;
        set_code(C_NONE);
        io_sel = 2'd0; cpu_data_out = 8'h00; pram_data = 8'h00; dram_rdata = 8'h00; io_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin exp_rd[i] = 8'h00; exp_dwd[i] = 8'h00; exp_iwd[i] = 8'h00; end
        @(posedge clk); @(posedge clk); #1;
        check("reset_a", 64'(obs(0)), 64'h0);
        check("reset_b", 64'(obs(1)), 64'h0);
        reset = 1'b0;

        // Directed table: whole-transaction summaries compared with hand-derived values.
        for (int t = 0; t < 9; t++) begin
            pram_data = tbl[t].pram; dram_rdata = tbl[t].dram; io_rdata = tbl[t].iord;
            run_txn(tbl[t].code, tbl[t].sel, tbl[t].wd, tbl[t].hold, 1, $sformatf("tbl%0d", t));
            for (int i = 0; i < 2; i++) begin
                ov = {8'(ob_wait[i]), 8'(ob_done[i]), 8'(ob_didx[i]), obs(i)[31:24], 8'(ob_dwe[i]),
                      ob_iowe[i], 8'(ob_err[i])};
                xv = {8'(tbl[t].e_wait), 8'((tbl[t].e_didx < 0) ? 0 : 1), 8'(tbl[t].e_didx),
                      (i == 0) ? tbl[t].e_rd_a : tbl[t].e_rd_b, 8'(tbl[t].e_dwe),
                      (i == 0) ? tbl[t].e_iowe_a : tbl[t].e_iowe_b,
                      8'((i == 0) ? tbl[t].e_err_a : tbl[t].e_err_b)};
                check($sformatf("tbl%0d_summary_%s", t, (i == 0) ? "a" : "b"), ov, xv);
            end
        end

        // Abort by switching to another valid code: the new code starts one edge later.
        pram_data = 8'h5D; dram_rdata = 8'h11;
        set_code(C_DRD);
        @(posedge clk); #1;
        check("sw_e0_wait", 64'(a_wait), 64'd1);
        set_code(C_FETCH);
        @(posedge clk); #1;
        check("sw_e1_abort", 64'({a_wait, a_done, b_wait, b_done}), 64'd0);
        check("sw_e1_rd", 64'(a_rd), 64'(exp_rd[0]));
        @(posedge clk); #1;
        check("sw_e2_accept", 64'({a_wait, a_done}), 64'b10);
        @(posedge clk); #1;
        check("sw_e3_done", 64'({a_wait, a_done, a_rd}), 64'({2'b01, 8'h5D}));
        exp_rd[0] = 8'h5D; exp_rd[1] = 8'h5D;
        set_code(C_NONE);
        @(posedge clk); #1;
        check("sw_e4_quiet", 64'({a_wait, a_done}), 64'd0);

        // Reset during an I/O write access discards it and clears every output at once.
        set_code(C_IOWR); io_sel = 2'd1; cpu_data_out = 8'hE7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_inaccess", 64'(a_wait), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_async_a", 64'(obs(0)), 64'h0);
        check("rst_mid_async_b", 64'(obs(1)), 64'h0);
        set_code(C_NONE);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin exp_rd[i] = 8'h00; exp_dwd[i] = 8'h00; exp_iwd[i] = 8'h00; end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid_quiet%0d", k), 64'({obs(0), obs(1)}), 64'h0);
        end
        run_txn(C_IOWR, 2'd1, 8'h42, 5, 1, "post_rst");
        check("post_rst_iowe", 64'({ob_iowe[0], ob_iowe[1]}), 64'h22);

        // Randomized accesses, both complete and aborted, checked cycle by cycle.
        for (int r = 0; r < 60; r++) begin
            c = codes[$urandom_range(0, 4)];
            w = wait_of(c);
            pram_data = 8'($urandom); dram_rdata = 8'($urandom); io_rdata = $urandom;
            if ($urandom_range(0, 3) != 0) hold = w + 2 + $urandom_range(0, 3);
            else hold = $urandom_range(1, w + 1);
            run_txn(c, 2'($urandom_range(0, 3)), 8'($urandom), hold, $urandom_range(1, 3),
                    $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_ctrl.md
# z80_bus_ctrl

Parametrised, clocked data-bus controller for the Z80 core. It decodes the CPU strobe code {m1, wr, rd, mreq} into program-RAM fetch, data-RAM read/write and I/O read/write accesses. Per-target wait states are inserted, and read data is latched into a register before it is returned to the CPU. Write data is routed to data RAM or to one of N_IO I/O channels with single-cycle write strobes. It sits between the CPU core and the PRAM/DRAM/IO blocks, and replaces the purely combinational bus multiplexer.

## Interface
Parameters:
- DATA_W, 8: data width of all data ports.
- N_IO, 4: number of I/O channels (1..16).
- IO_SEL_W, 2: width of io_sel; 2^IO_SEL_W ≥ N_IO.
- PRAM_WAIT, 0: wait cycles for a program fetch.
- DRAM_WAIT, 1: wait cycles for a DRAM read or write.
- IO_WAIT, 2: wait cycles for an I/O read or write (all WAIT values 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m1, wr, rd, mreq  in  1 each  CPU strobe code.
- io_sel  in  IO_SEL_W  I/O channel select.
- cpu_data_out  in  DATA_W  CPU write data.
- cpu_data_in  out  DATA_W  registered read data to CPU.
- cpu_wait  out  1  high while an access is in progress.
- cycle_done  out  1  one-cycle pulse on access completion.
- bus_err  out  1  one-cycle pulse on an I/O access with io_sel ≥ N_IO.
- pram_data  in  DATA_W  program RAM data.
- dram_rdata  in  DATA_W  data RAM read data.
- dram_wdata  out  DATA_W  data RAM write data.
- dram_we  out  1  data RAM write strobe.
- io_rdata  in  N_IO*DATA_W  I/O read data, channel k at bits [k*DATA_W +: DATA_W].
- io_wdata  out  DATA_W  I/O write data.
- io_we  out  N_IO  one-hot I/O write strobes.

## Operation
- Code {m1,wr,rd,mreq} decoding:
  - 0100: FETCH.
  - 1100: DRAM_RD.
  - 1101: IO_RD.
  - 1010: DRAM_WR.
  - 1011: IO_WR.
  - All other codes: NONE.
- States: IDLE, ACCESS, HOLD.
- IDLE:
  - On a valid code: latch the type, io_sel and cpu_data_out.
  - Load wait counter cnt with the target's WAIT value.
  - Go to ACCESS.
- ACCESS, cnt > 0: decrement cnt.
- ACCESS, cnt == 0, completion:
  - Reads: load cpu_data_in from pram_data, dram_rdata or the selected io_rdata slice.
  - Writes: drive dram_wdata/io_wdata with the latched data and pulse dram_we or io_we[sel] for one cycle.
  - Pulse cycle_done.
  - Go to HOLD.
- HOLD: stay until the code decodes to NONE, then go to IDLE. A held code never causes a second access.
- Abort: if the code changes from the latched type during ACCESS, go to IDLE.
  - No strobe, no cycle_done.
  - cpu_data_in is unchanged.
  - The new code is not accepted in that same cycle.
- Bad I/O select (io_sel ≥ N_IO):
  - Read: returns all-zero data.
  - Write: no io_we bit asserted.
  - bus_err pulses together with cycle_done.
- cpu_data_in holds its last value between accesses. It is never forced to zero by NONE.
- dram_wdata and io_wdata hold the last written data.
- Reset: state IDLE, cnt 0, and all outputs (cpu_data_in, dram_wdata, io_wdata, dram_we, io_we, cpu_wait, cycle_done, bus_err) are 0. Reset mid-access discards the access with no strobe.

## Timing
- Code sampled at edge E0 → ACCESS.
- cpu_wait = (state == ACCESS). It is high from E0 to E(W+1), where W is the target's WAIT value.
- Completion is registered at edge E(W+1):
  - cpu_data_in updates.
  - Strobes, cycle_done and bus_err are high for exactly the cycle after E(W+1).
- Access latency is W+1 clocks from code sampling to data/strobe. W=0 gives 1 clock.
- Minimum spacing between accesses: W+3 clocks (ACCESS W+1, HOLD ≥1, IDLE 1).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: DATA_W=8, N_IO=4, PRAM_WAIT=0, DRAM_WAIT=2, IO_WAIT=3.

1. Reset, then FETCH with pram_data=8'hA5 → cpu_wait high 1 cycle; cpu_data_in=8'hA5 one edge after sampling; cycle_done pulse.
2. DRAM_WR (1010), cpu_data_out=8'h3C → cpu_wait high 3 cycles; dram_we high exactly 1 cycle with dram_wdata=8'h3C; code held 10 cycles → no second dram_we.
3. IO_RD with io_sel=2, io_rdata slice 2=8'h7E, others 8'hFF → cpu_data_in=8'h7E after 4 clocks; bus_err stays 0.
4. IO_WR with io_sel=3 → io_we=4'b1000 for one cycle, 4 clocks after sampling. Then repeat with N_IO=3: io_we=0, bus_err pulses with cycle_done.
5. DRAM_RD with cnt=1, then the code changes to 0000 → no cycle_done; cpu_data_in keeps its previous value; FSM back in IDLE.
6. Assert reset during IO_WR ACCESS → no io_we pulse; all outputs 0 immediately; the next access completes normally.
